mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle integer multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU).
//  Consumes operands from the A/B operand registers; produces the HI/LO pair for the register-bank write-back mux.
//  Control unit issues a start pulse, then holds in a wait state until done.
//  Iterative radix-2 engine: one shift-add (multiply) or restoring-subtract (divide) step per clock.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clock     in   1      single system clock, rising edge
//  reset     in   1      synchronous, active-low (0 = reset), sampled on clock rising edge
//  start     in   1      begin operation; sampled only in IDLE
//  op        in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  a         in   WIDTH  multiplicand / dividend
//  b         in   WIDTH  multiplier / divisor
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse: HI/LO updated
//  hi        out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//  lo        out  WIDTH  MUL: product[W-1:0];  DIV: quotient
//  div_zero  out  1      divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; any in-flight op aborted, no partial result visible.
//  FSM: IDLE -> LOAD -> ITER (WIDTH cycles) -> FIX -> IDLE.
//   IDLE: start==1 at edge -> LOAD; a, b, op latched at that same edge. start==0 -> stay.
//   LOAD: latch operand magnitudes (signed ops: abs value; unsigned: raw); record result signs; counter=0; busy=1 -> ITER.
//   ITER: one step per edge; counter increments; after step WIDTH-1 -> FIX.
//   FIX: apply sign correction; write hi/lo; done=1, busy=0 for the following cycle -> IDLE.
//  Latency: start sampled at edge E0; done high during the cycle after edge E0+WIDTH+2 (34 edges for WIDTH=32).
//  busy: high from edge E0+1 until the edge that raises done; busy and done are never both high.
//  A new op may start in the cycle done is high (back-to-back).
//  start while busy: ignored; a/b/op changes while busy: no effect.
//  hi/lo: hold the previous result from reset or last done until the next FIX edge.
//  Multiply: 2*WIDTH-bit unsigned product of magnitudes; MULT negates the full 2W-bit product if sign(a)!=sign(b).
//  Divide: restoring; quotient negative if sign(a)!=sign(b); remainder takes the sign of the dividend (|rem|<|b|).
//  Overflow: DIV -2^(W-1) / -1 -> lo=0x80000000, hi=0 (wraps; no flag).
//  Divide by zero (b==0, DIV/DIVU): same latency. Without the macro: lo=all-ones, hi=a (unmodified dividend).
// CONFIGURATION
//  DIV_BY_ZERO_EXC_EN defined: on a divide with b==0, div_zero=1 in the same cycle as done; hi/lo keep their previous values (not written).
//   div_zero=0 for all other ops. The control unit uses the flag to raise an arithmetic exception.
//  DIV_BY_ZERO_EXC_EN undefined: div_zero tied to 0; divide-by-zero result as in BEHAVIOUR.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start edge; busy high 33 cycles.
//  MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002.
//  DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
//  DIV a=0x1234 b=0 -> macro off: lo=0xFFFFFFFF, hi=0x1234, div_zero=0; macro on: div_zero=1 with done, hi/lo unchanged.
//  Pulse start again at cycle 10 of a MULTU; change a/b mid-op -> ignored, result matches the original operands, single done.
//  reset=0 at ITER cycle 15 -> next cycle busy=0, done=0, hi=lo=0; new start after release completes normally with correct result.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) producing HI/LO.
// Optional macro DIV_BY_ZERO_EXC_EN: flag divide-by-zero and leave HI/LO untouched.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_up;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_div;
    logic             w_signed;
    logic             w_b_zero;
    logic             w_dz_exc;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shrem;
    logic             w_ge;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_up_nxt;
    logic [WIDTH-1:0] w_low_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_b_zero = (r_b == '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_BY_ZERO_EXC_EN
    assign w_dz_exc = w_is_div & w_b_zero;
`else
    assign w_dz_exc = 1'b0;
`endif

    assign w_mag_a = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_mag_b = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Multiply: add multiplicand on LSB, shift {up,low} right.
    // Divide: shift {up,low} left, subtract divisor when it fits.
    assign w_sum   = {1'b0, r_up} + (r_low[0] ? {1'b0, r_mcand} : '0);
    assign w_shrem = {r_up, r_low[WIDTH-1]};
    assign w_ge    = (w_shrem >= {1'b0, r_mcand});
    assign w_trial = w_shrem - {1'b0, r_mcand};

    always_comb begin
        w_up_nxt  = r_up;
        w_low_nxt = r_low;
        if (w_is_div) begin
            if (w_ge) begin
                w_up_nxt  = w_trial[WIDTH-1:0];
                w_low_nxt = {r_low[WIDTH-2:0], 1'b1};
            end else begin
                w_up_nxt  = w_shrem[WIDTH-1:0];
                w_low_nxt = {r_low[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_up_nxt  = w_sum[WIDTH:1];
            w_low_nxt = {w_sum[0], r_low[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = {r_up, r_low};
        w_hi_res = r_up;
        w_lo_res = r_low;
        if (w_is_div) begin
            if (w_b_zero) begin
                w_hi_res = r_a;
                w_lo_res = '1;
            end else begin
                w_hi_res = r_neg_r ? -r_up : r_up;
                w_lo_res = r_neg_q ? -r_low : r_low;
            end
        end else begin
            if (r_neg_q) begin
                w_prod = -{r_up, r_low};
            end
            w_hi_res = w_prod[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = S_ITER;
            S_ITER: if (w_last) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_up    <= '0;
            r_low   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= op;
                    end
                end
                S_LOAD: begin
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_up    <= '0;
                    r_low   <= w_is_div ? w_mag_a : w_mag_b;
                    r_mcand <= w_is_div ? w_mag_b : w_mag_a;
                    r_neg_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= w_signed & r_a[WIDTH-1];
                end
                S_ITER: begin
                    r_up  <= w_up_nxt;
                    r_low <= w_low_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (w_dz_exc) begin
                        r_dz <= 1'b1;
                    end else begin
                        r_hi <= w_hi_res;
                        r_lo <= w_lo_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus multi-cycle corner sequences.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_tests;
    int n_fail;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; returns edges to done and busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output int nbusy, output int overlap);
        lat = -1;
        nbusy = 0;
        overlap = 0;
        @(negedge clock);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock);
            #1;
            if (busy && done) overlap++;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, nb, ov, ndone;
    logic [31:0] prev_hi, prev_lo;

    initial begin
        n_tests = 0;
        n_fail = 0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[6]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        vecs[10] = '{2'b01, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000};
        vecs[11] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;

        // Ops are issued back-to-back: each start lands in the done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb, ov);
            check($sformatf("v%0d_latency", i), lat, 34);
            check($sformatf("v%0d_busy_cycles", i), nb, 33);
            check($sformatf("v%0d_overlap", i), ov, 0);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_dz", i), {31'd0, div_zero}, 32'd0);
        end

        @(posedge clock);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("hold_hi", hi, 32'hFFFFFFFE);
        check("hold_lo", lo, 32'h0000000E);

        // Divide by zero
        run_op(2'b01, 32'h00010000, 32'h00010000, lat, nb, ov);
        prev_hi = hi;
        prev_lo = lo;
        run_op(2'b10, 32'h00001234, 32'd0, lat, nb, ov);
        check("dz_latency", lat, 34);
`ifdef DIV_BY_ZERO_EXC_EN
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        check("dz_hi", hi, prev_hi);
        check("dz_lo", lo, prev_lo);
`else
        check("dz_flag", {31'd0, div_zero}, 32'd0);
        check("dz_hi", hi, 32'h00001234);
        check("dz_lo", lo, 32'hFFFFFFFF);
        if (prev_hi !== 32'h1) check("dz_prev_hi", prev_hi, 32'h1);
`endif
        @(posedge clock);
        #1;
        check("dz_flag_clear", {31'd0, div_zero}, 32'd0);

        // Restart and operand changes while busy are ignored
        @(negedge clock);
        op = 2'b01;
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        ndone = 0;
        lat = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == 10) begin
                start = 1'b1;
                op = 2'b10;
                a = 32'd7;
                b = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        check("restart_ndone", ndone, 1);
        check("restart_latency", lat, 34);
        check("restart_hi", hi, 32'd0);
        check("restart_lo", lo, 32'd15);

        // Reset during ITER
        @(negedge clock);
        op = 2'b01;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (16) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_late_done", ndone, 0);
        run_op(2'b11, 32'd100, 32'd7, lat, nb, ov);
        check("postrst_latency", lat, 34);
        check("postrst_hi", hi, 32'd2);
        check("postrst_lo", lo, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
